// File: rtl/scan_scheduler_if.sv
// Handshake bundle between the scan scheduler and its surroundings
// (parameter buffer, membership datapath, output port).
interface scan_scheduler_if #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 7
) ();
  logic               en_i;
  logic               hold_i;
  logic               hit_i;
  logic               load_o;
  logic               busy_o;
  logic [COORD_W-1:0] coord_x_o;
  logic [COORD_W-1:0] coord_y_o;
  logic               coord_vld_o;
  logic [CNT_W-1:0]   candidate_o;
  logic               valid_o;

  modport slave (
    input  en_i, hold_i, hit_i,
    output load_o, busy_o, coord_x_o, coord_y_o, coord_vld_o, candidate_o, valid_o
  );

  modport master (
    output en_i, hold_i, hit_i,
    input  load_o, busy_o, coord_x_o, coord_y_o, coord_vld_o, candidate_o, valid_o
  );
endinterface

// File: rtl/scan_scheduler.sv
// Raster-scans the candidate grid through the membership pipeline and counts hits,
// tracking each issued point through a PIPE_LAT-deep shift register.
module scan_scheduler #(
  parameter int COORD_W  = 4,
  parameter int GRID_MIN = 1,
  parameter int GRID_MAX = 8,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  scan_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [COORD_W-1:0] MIN_C   = COORD_W'(GRID_MIN);
  localparam logic [COORD_W-1:0] MAX_C   = COORD_W'(GRID_MAX);
  localparam logic [COORD_W-1:0] ONE_X   = COORD_W'(1);
  localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0]     cand_q, cand_d;
  logic [PIPE_LAT-1:0]  track_q, track_d;
  logic                 issue_s;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cand_d  = cand_q;
    issue_s = (state_q == SCAN) && !bus.hold_i;
    track_d = (track_q << 1'b1) | PIPE_LAT'(issue_s);

    // Oldest tracking bit marks the cycle whose hit_i belongs to an issued point.
    if (track_q[PIPE_LAT-1] && bus.hit_i && (cand_q != CNT_MAX)) begin
      cand_d = cand_q + ONE_C;
    end else begin
      cand_d = cand_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.en_i) state_d = LOAD;
        else          state_d = IDLE;
      end
      LOAD: begin
        cand_d  = '0;
        x_d     = MIN_C;
        y_d     = MIN_C;
        state_d = SCAN;
      end
      SCAN: begin
        if (issue_s) begin
          if (x_q == MAX_C) begin
            if (y_q == MAX_C) begin
              state_d = DRAIN;
            end else begin
              x_d = MIN_C;
              y_d = y_q + ONE_X;
            end
          end else begin
            x_d = x_q + ONE_X;
          end
        end else begin
          state_d = SCAN;
        end
      end
      DRAIN: begin
        if (track_d == '0) state_d = DONE;
        else               state_d = DRAIN;
      end
      DONE: begin
        if (bus.en_i) state_d = LOAD;
        else          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= MIN_C;
      y_q     <= MIN_C;
      cand_q  <= '0;
      track_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cand_q  <= cand_d;
      track_q <= track_d;
    end
  end

  assign bus.load_o      = (state_q == LOAD);
  assign bus.busy_o      = (state_q == LOAD) || (state_q == SCAN) || (state_q == DRAIN);
  assign bus.valid_o     = (state_q == DONE);
  assign bus.coord_vld_o = issue_s;
  assign bus.coord_x_o   = x_q;
  assign bus.coord_y_o   = y_q;
  assign bus.candidate_o = cand_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench: a queue-based reference of the scan (point index, pending
// results with due cycles) is compared against the DUT on every falling edge.
module tb_scan_scheduler;
  localparam int LAT  = 2;
  localparam int GMIN = 1;
  localparam int N    = 8;
  localparam int NPTS = N * N;
  localparam int CMAX = 127;
  localparam int P_IDLE = 0, P_LOAD = 1, P_SCAN = 2, P_DRAIN = 3, P_DONE = 4;

  typedef struct { int due; int x; int y; } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  scan_scheduler_if #(.COORD_W(4), .CNT_W(7)) bus ();

  scan_scheduler #(
    .COORD_W(4), .GRID_MIN(GMIN), .GRID_MAX(GMIN + N - 1), .PIPE_LAT(LAT), .CNT_W(7)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int    m_phase = P_IDLE;
  int    m_idx   = 0;
  int    m_cnt   = 0;
  pend_t pend[$];

  int hit_mode  = 1;
  bit rand_mode = 1'b0;
  bit en_req    = 1'b0;
  int hold_idx  = -1;
  int hold_len  = 0;
  int hold_cnt  = 0;
  bit dh_armed  = 1'b0;
  int dh_left   = 0;
  int en_idx    = -1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rx(input int i);
    int j;
    j = (i > NPTS - 1) ? NPTS - 1 : i;
    return GMIN + (j % N);
  endfunction

  function automatic int ry(input int i);
    int j;
    j = (i > NPTS - 1) ? NPTS - 1 : i;
    return GMIN + (j / N);
  endfunction

  // Reference model and per-cycle comparison, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = P_IDLE;
        m_idx   = 0;
        m_cnt   = 0;
        pend.delete();
      end
      check("load_o",      int'(bus.load_o),      int'(m_phase == P_LOAD));
      check("busy_o",      int'(bus.busy_o),      int'(m_phase == P_LOAD || m_phase == P_SCAN || m_phase == P_DRAIN));
      check("valid_o",     int'(bus.valid_o),     int'(m_phase == P_DONE));
      check("coord_vld_o", int'(bus.coord_vld_o), int'(m_phase == P_SCAN && !bus.hold_i));
      check("coord_x_o",   int'(bus.coord_x_o),   rx(m_idx));
      check("coord_y_o",   int'(bus.coord_y_o),   ry(m_idx));
      check("candidate_o", int'(bus.candidate_o), m_cnt);
      if (!rst) begin
        if (pend.size() > 0 && pend[0].due == cyc) begin
          if (bus.hit_i && m_cnt < CMAX) m_cnt++;
          void'(pend.pop_front());
        end
        case (m_phase)
          P_IDLE:  if (bus.en_i) m_phase = P_LOAD;
          P_LOAD:  begin m_cnt = 0; m_idx = 0; m_phase = P_SCAN; end
          P_SCAN:  if (!bus.hold_i) begin
                     pend.push_back('{cyc + LAT, rx(m_idx), ry(m_idx)});
                     m_idx++;
                     if (m_idx == NPTS) m_phase = P_DRAIN;
                   end
          P_DRAIN: if (pend.size() == 0) m_phase = P_DONE;
          P_DONE:  if (bus.en_i) m_phase = P_LOAD;
          default: m_phase = P_IDLE;
        endcase
      end
      cyc++;
    end
  end

  task automatic step();
    bit h;
    bit due_now;
    @(posedge clk);
    #2;
    h = 1'b0;
    if (rand_mode) h = ($urandom_range(0, 3) == 0);
    if (m_phase == P_SCAN && m_idx == hold_idx && hold_cnt < hold_len) begin
      h = 1'b1;
      hold_cnt++;
    end
    if (m_phase == P_DRAIN && dh_armed) begin
      dh_armed = 1'b0;
      dh_left  = 3;
    end
    if (dh_left > 0) begin
      h = 1'b1;
      dh_left--;
    end
    bus.hold_i = h;
    bus.en_i = en_req || (m_phase == P_SCAN && m_idx == en_idx) ||
               (rand_mode && $urandom_range(0, 15) == 0);
    due_now = (pend.size() > 0) && (pend[0].due == cyc);
    case (hit_mode)
      0:       bus.hit_i = 1'($urandom_range(0, 1));
      1:       bus.hit_i = 1'b1;
      2:       bus.hit_i = 1'b0;
      default: bus.hit_i = due_now ? (pend[0].x == 3 && pend[0].y == 5) : 1'b1;
    endcase
  endtask

  task automatic run_scan(input string name, input int exp_lat, input int exp_cnt);
    int t;
    int n;
    en_req = 1'b1;
    step();
    t = cyc;
    en_req = 1'b0;
    step();
    check({name, " load_o at t+1"},  int'(bus.load_o),  1);
    check({name, " valid_o at t+1"}, int'(bus.valid_o), 0);
    n = 0;
    while (!bus.valid_o && n < 200) begin
      step();
      n++;
    end
    check({name, " valid latency"}, cyc - t, exp_lat);
    check({name, " final count"},   int'(bus.candidate_o), exp_cnt);
  endtask

  initial begin
    int n;
    bus.en_i   = 1'b0;
    bus.hold_i = 1'b0;
    bus.hit_i  = 1'b0;
    step();
    step();
    check("reset busy_o",      int'(bus.busy_o), 0);
    check("reset coord_x_o",   int'(bus.coord_x_o), GMIN);
    check("reset candidate_o", int'(bus.candidate_o), 0);
    rst = 1'b0;
    step();

    hit_mode = 1;  run_scan("T1", 68, 64);
    hit_mode = 2;  run_scan("T2", 68, 0);
    hit_mode = 3;  run_scan("T3", 68, 1);

    hit_mode = 1; hold_idx = 15; hold_len = 5; hold_cnt = 0; dh_armed = 1'b1;
    run_scan("T4", 73, 64);
    hold_idx = -1; dh_armed = 1'b0; dh_left = 0;

    en_idx = 27;  run_scan("T5", 68, 64);
    en_idx = -1;

    en_req = 1'b1;
    step();
    en_req = 1'b0;
    n = 0;
    while (!(m_phase == P_SCAN && m_idx == 21) && n < 100) begin
      step();
      n++;
    end
    check("T6 reached (6,3)", int'(bus.coord_x_o) * 16 + int'(bus.coord_y_o), 6 * 16 + 3);
    rst = 1'b1;
    #1;
    check("T6 async busy_o",      int'(bus.busy_o), 0);
    check("T6 async coord_x_o",   int'(bus.coord_x_o), GMIN);
    check("T6 async coord_y_o",   int'(bus.coord_y_o), GMIN);
    check("T6 async coord_vld_o", int'(bus.coord_vld_o), 0);
    check("T6 async candidate_o", int'(bus.candidate_o), 0);
    step();
    step();
    rst = 1'b0;
    step();
    run_scan("T6 rescan", 68, 64);

    hit_mode  = 0;
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0;
    n = 0;
    while (!(m_phase == P_IDLE || m_phase == P_DONE) && n < 200) begin
      step();
      n++;
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
